fifo_rd_ctrl: RTL and testbench

Read-side controller for the team's async FIFO. It runs in the read clock domain and drives the read address into the FIFO memory, whose read port is combinational. It synchronises the write-domain Gray pointer, generates EMPTY, and exports its own Gray read pointer back to the write domain. Read data is delivered through a one-entry registered prefetch stage with a valid/ready handshake, so consumers see registered data at one word per clock.

---
 rtl/fifo_rd_ctrl_if.sv | 27 ++
 rtl/fifo_rd_ctrl.sv | 89 ++++++++
 tb/tb_fifo_rd_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus of the async FIFO: memory read port, pointer exchange
// with the write domain, and the consumer valid/ready handshake.
interface fifo_rd_ctrl_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 3
);
  logic [ADDRESS_WIDTH:0]   W_PTR_GRAY;
  logic [ADDRESS_WIDTH-1:0] R_ADDR;
  logic [DATA_WIDTH-1:0]    MEM_RD_DATA;
  logic [ADDRESS_WIDTH:0]   R_PTR_GRAY;
  logic                     EMPTY;
  logic [DATA_WIDTH-1:0]    RD_DATA;
  logic                     RD_VALID;
  logic                     RD_READY;

  // Controller side
  modport master (
    input  W_PTR_GRAY, MEM_RD_DATA, RD_READY,
    output R_ADDR, R_PTR_GRAY, EMPTY, RD_DATA, RD_VALID
  );

  // Memory / write domain / consumer side
  modport slave (
    output W_PTR_GRAY, MEM_RD_DATA, RD_READY,
    input  R_ADDR, R_PTR_GRAY, EMPTY, RD_DATA, RD_VALID
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read controller: synchronises the write Gray pointer, derives
// EMPTY, drives the memory read address and delivers data through a
// one-entry registered prefetch stage with a valid/ready handshake.
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 3
) (
  input  logic              R_CLK,
  input  logic              R_RST,
  fifo_rd_ctrl_if.master    bus
);

  localparam int PW = ADDRESS_WIDTH + 1;

  // Binary to reflected Gray code
  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PW-1:0]         rbin_q, rbin_d;
  logic [PW-1:0]         rgray_q, rgray_d;
  logic [PW-1:0]         wq1_q, wq2_q;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [PW-1:0]         rbin_inc_s;
  logic                  empty_s;
  logic                  fetch_s;

  // Storage is empty when our pointer has caught up with the synchronised
  // write pointer; the word in the output stage is not counted.
  assign empty_s    = (rgray_q == wq2_q);
  // Fetch whenever storage has a word and the output stage is free or
  // being drained this cycle.
  assign fetch_s    = ~empty_s & (~rd_valid_q | bus.RD_READY);
  assign rbin_inc_s = rbin_q + {{ADDRESS_WIDTH{1'b0}}, 1'b1};

  assign bus.R_ADDR     = rbin_q[ADDRESS_WIDTH-1:0];
  assign bus.R_PTR_GRAY = rgray_q;
  assign bus.EMPTY      = empty_s;
  assign bus.RD_DATA    = rd_data_q;
  assign bus.RD_VALID   = rd_valid_q;

  // Two-flop synchroniser for the write-domain Gray pointer, no logic between stages
  always_ff @(posedge R_CLK) begin
    if (!R_RST) begin
      wq1_q <= '0;
      wq2_q <= '0;
    end else begin
      wq1_q <= bus.W_PTR_GRAY;
      wq2_q <= wq1_q;
    end
  end

  // Next-state for pointers and the output stage
  always_comb begin
    rbin_d     = rbin_q;
    rgray_d    = rgray_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    if (fetch_s) begin
      // New word replaces the old one even when it is accepted this cycle
      rd_data_d  = bus.MEM_RD_DATA;
      rd_valid_d = 1'b1;
      rbin_d     = rbin_inc_s;
      rgray_d    = bin2gray(rbin_inc_s);
    end else if (rd_valid_q && bus.RD_READY) begin
      rd_valid_d = 1'b0;
    end else begin
      // Stalled or idle: data stays stable until accepted
      rd_valid_d = rd_valid_q;
    end
  end

  // Pointer and output-stage registers; reset discards any held word
  always_ff @(posedge R_CLK) begin
    if (!R_RST) begin
      rbin_q     <= '0;
      rgray_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rbin_q     <= rbin_d;
      rgray_q    <= rgray_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a scoreboard-driven data monitor.
module tb_fifo_rd_ctrl;

  logic R_CLK;
  logic R_RST;
  logic [7:0] mem [8];

  int total_cnt = 0;
  int pass_cnt  = 0;
  logic [7:0] sb_q [$];

  fifo_rd_ctrl_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(3)) bus ();

  fifo_rd_ctrl #(.DATA_WIDTH(8), .ADDRESS_WIDTH(3)) dut (
    .R_CLK (R_CLK),
    .R_RST (R_RST),
    .bus   (bus)
  );

  assign bus.MEM_RD_DATA = mem[bus.R_ADDR];

  initial R_CLK = 1'b0;
  always #5 R_CLK = ~R_CLK;

  function automatic logic [3:0] gray(input int b);
    logic [3:0] x;
    x = b[3:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge R_CLK);
    #1;
  endtask

  // Monitor: every accepted word must match the head of the scoreboard,
  // and a stalled word must stay stable.
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data;
  always @(negedge R_CLK) begin
    if (R_RST !== 1'b1) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend && bus.RD_VALID === 1'b1)
        chk("hold_stable", {24'd0, bus.RD_DATA}, {24'd0, hold_data});
      hold_pend = 1'b0;
      if (bus.RD_VALID === 1'b1 && bus.RD_READY === 1'b1) begin
        if (sb_q.size() == 0) begin
          total_cnt++;
          $display("FAIL sb_unexpected: got %0h expected no word", bus.RD_DATA);
        end else begin
          chk("sb_data", {24'd0, bus.RD_DATA}, {24'd0, sb_q.pop_front()});
        end
      end else if (bus.RD_VALID === 1'b1) begin
        hold_pend = 1'b1;
        hold_data = bus.RD_DATA;
      end
    end
  end

  task automatic do_reset(input logic flush);
    R_RST = 1'b0;
    bus.W_PTR_GRAY = 4'b0000;
    bus.RD_READY = 1'b0;
    cyc();
    cyc();
    if (flush) sb_q.delete();
    else chk("sb_drained", sb_q.size(), 32'd0);
    R_RST = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb_q.size() == 0 && bus.RD_VALID == 1'b0) break;
      cyc();
    end
    chk("drain_done", {31'd0, (sb_q.size() == 0 && bus.RD_VALID == 1'b0)}, 32'd1);
  endtask

  logic [2:0] addr_seen [4];
  logic [3:0] gray_seen [4];
  int n_fetch;
  logic [2:0] exp_addr [4];
  logic [3:0] exp_gray [4];

  initial begin
    R_RST = 1'b0;
    bus.W_PTR_GRAY = 4'b0011;
    bus.RD_READY = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;

    // 1: reset holds everything cleared despite a nonzero write pointer
    for (int e = 0; e < 2; e++) begin
      cyc();
      chk("rst_addr", {29'd0, bus.R_ADDR}, 32'd0);
      chk("rst_gray", {28'd0, bus.R_PTR_GRAY}, 32'd0);
      chk("rst_valid", {31'd0, bus.RD_VALID}, 32'd0);
      chk("rst_data", {24'd0, bus.RD_DATA}, 32'd0);
      chk("rst_empty", {31'd0, bus.EMPTY}, 32'd1);
    end
    bus.W_PTR_GRAY = 4'b0000;
    cyc();
    cyc();
    R_RST = 1'b1;
    cyc();

    // 2: single word with 3-edge latency, held until accepted
    mem[0] = 8'hA5;
    sb_q.push_back(8'hA5);
    bus.W_PTR_GRAY = 4'b0001;
    cyc();
    chk("s2_empty_e0", {31'd0, bus.EMPTY}, 32'd1);
    cyc();
    chk("s2_empty_e1", {31'd0, bus.EMPTY}, 32'd0);
    chk("s2_valid_e1", {31'd0, bus.RD_VALID}, 32'd0);
    cyc();
    chk("s2_valid_e2", {31'd0, bus.RD_VALID}, 32'd1);
    chk("s2_data_e2", {24'd0, bus.RD_DATA}, 32'hA5);
    chk("s2_gray_e2", {28'd0, bus.R_PTR_GRAY}, 32'b0001);
    chk("s2_empty_e2", {31'd0, bus.EMPTY}, 32'd1);
    cyc();
    cyc();
    chk("s2_hold_valid", {31'd0, bus.RD_VALID}, 32'd1);
    chk("s2_hold_data", {24'd0, bus.RD_DATA}, 32'hA5);
    bus.RD_READY = 1'b1;
    cyc();
    chk("s2_accepted", {31'd0, bus.RD_VALID}, 32'd0);
    chk("s2_sb", sb_q.size(), 32'd0);

    // 3: streaming eight words at one per cycle
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      mem[i] = 8'h10 + 8'(i);
      sb_q.push_back(8'h10 + 8'(i));
    end
    bus.RD_READY = 1'b1;
    bus.W_PTR_GRAY = 4'b1100;
    for (int k = 0; k < 12; k++) begin
      cyc();
      chk("s3_valid", {31'd0, bus.RD_VALID}, {31'd0, (k >= 2 && k <= 9)});
    end
    chk("s3_gray", {28'd0, bus.R_PTR_GRAY}, 32'b1100);
    chk("s3_empty", {31'd0, bus.EMPTY}, 32'd1);
    chk("s3_addr", {29'd0, bus.R_ADDR}, 32'd0);

    // 4: backpressure after the second word
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) sb_q.push_back(8'h10 + 8'(i));
    bus.RD_READY = 1'b1;
    bus.W_PTR_GRAY = 4'b1100;
    cyc(); cyc(); cyc();
    chk("s4_first", {24'd0, bus.RD_DATA}, 32'h10);
    cyc();
    chk("s4_second", {24'd0, bus.RD_DATA}, 32'h11);
    bus.RD_READY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("s4_bp_data", {24'd0, bus.RD_DATA}, 32'h11);
      chk("s4_bp_gray", {28'd0, bus.R_PTR_GRAY}, 32'b0011);
      chk("s4_bp_valid", {31'd0, bus.RD_VALID}, 32'd1);
    end
    bus.RD_READY = 1'b1;
    drain(20);
    chk("s4_gray", {28'd0, bus.R_PTR_GRAY}, 32'b1100);

    // 5: wrap-around from rbin=14
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) mem[i] = 8'h30 + 8'(i);
    for (int i = 0; i < 14; i++) sb_q.push_back(8'h30 + 8'(i % 8));
    bus.RD_READY = 1'b1;
    bus.W_PTR_GRAY = gray(14);
    drain(30);
    chk("s5_pre_addr", {29'd0, bus.R_ADDR}, 32'd6);
    chk("s5_pre_gray", {28'd0, bus.R_PTR_GRAY}, 32'b1001);
    chk("s5_pre_empty", {31'd0, bus.EMPTY}, 32'd1);
    sb_q.push_back(8'h36); sb_q.push_back(8'h37);
    sb_q.push_back(8'h30); sb_q.push_back(8'h31);
    exp_addr[0] = 3'd6; exp_addr[1] = 3'd7; exp_addr[2] = 3'd0; exp_addr[3] = 3'd1;
    exp_gray[0] = 4'b1001; exp_gray[1] = 4'b1000; exp_gray[2] = 4'b0000; exp_gray[3] = 4'b0001;
    bus.W_PTR_GRAY = gray(18);
    n_fetch = 0;
    for (int j = 0; j < 12; j++) begin
      if (bus.EMPTY == 1'b0) begin
        if (n_fetch < 4) begin
          addr_seen[n_fetch] = bus.R_ADDR;
          gray_seen[n_fetch] = bus.R_PTR_GRAY;
        end
        n_fetch++;
      end
      cyc();
    end
    chk("s5_nfetch", n_fetch, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("s5_addr", {29'd0, addr_seen[i]}, {29'd0, exp_addr[i]});
      chk("s5_gray", {28'd0, gray_seen[i]}, {28'd0, exp_gray[i]});
    end
    drain(10);
    chk("s5_end_gray", {28'd0, bus.R_PTR_GRAY}, 32'b0011);

    // 6: reset while a word is held under backpressure at rbin=5
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) sb_q.push_back(8'h30 + 8'(i));
    bus.RD_READY = 1'b1;
    bus.W_PTR_GRAY = 4'b1100;
    for (int j = 0; j < 20; j++) begin
      if (bus.R_PTR_GRAY == 4'b0111) break;
      cyc();
    end
    chk("s6_at_rbin5", {28'd0, bus.R_PTR_GRAY}, 32'b0111);
    bus.RD_READY = 1'b0;
    chk("s6_valid_pre", {31'd0, bus.RD_VALID}, 32'd1);
    chk("s6_data_pre", {24'd0, bus.RD_DATA}, 32'h34);
    R_RST = 1'b0;
    bus.W_PTR_GRAY = 4'b0000;
    cyc();
    chk("s6_addr", {29'd0, bus.R_ADDR}, 32'd0);
    chk("s6_gray", {28'd0, bus.R_PTR_GRAY}, 32'd0);
    chk("s6_valid", {31'd0, bus.RD_VALID}, 32'd0);
    chk("s6_data", {24'd0, bus.RD_DATA}, 32'd0);
    chk("s6_empty", {31'd0, bus.EMPTY}, 32'd1);
    chk("s6_sb_left", sb_q.size(), 32'd4);
    sb_q.delete();
    cyc();
    R_RST = 1'b1;
    cyc();
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
